// File: rtl/dmem_stall_if.sv
// dmem_stall_if: load/store port between the core and its data memory.
// The core drives the i_* request side; the memory returns o_* data and stall.
// o_err exists only when DMEM_BOUNDS_EN is defined.
interface dmem_stall_if #(
  parameter int DATA_W = 32
);
  logic                  i_ren;
  logic                  i_wen;
  logic [DATA_W/8-1:0]   i_wstrb;
  logic [31:0]           i_addr;
  logic [DATA_W-1:0]     i_wdata;
  logic [DATA_W-1:0]     o_rdata;
  logic                  o_rvalid;
  logic                  o_stall;
`ifdef DMEM_BOUNDS_EN
  logic                  o_err;
`endif

  modport master (
    output i_ren, i_wen, i_wstrb, i_addr, i_wdata,
`ifdef DMEM_BOUNDS_EN
    input  o_err,
`endif
    input  o_rdata, o_rvalid, o_stall
  );

  modport slave (
    input  i_ren, i_wen, i_wstrb, i_addr, i_wdata,
`ifdef DMEM_BOUNDS_EN
    output o_err,
`endif
    output o_rdata, o_rvalid, o_stall
  );
endinterface

// File: rtl/dmem_stall.sv
// dmem_stall: word-addressed data memory with byte-lane writes and a
// programmable access latency that stalls the core through o_stall.
// LATENCY=0 is a plain single-cycle memory; LATENCY>0 serializes each access
// through IDLE -> BUSY (LATENCY cycles) -> DONE.
// Optional macro DMEM_BOUNDS_EN: out-of-range accesses are suppressed, read
// as zero and flagged on o_err in the completion cycle.
module dmem_stall #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic         clk,
  input  logic         rst,
  dmem_stall_if.slave  bus
);
  localparam int NB    = DATA_W / 8;
  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]     mem [WORDS];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  req;
  logic                  req_oor;

  assign idx = bus.i_addr[DEPTH_LOG2+1:2];
  assign req = bus.i_ren | bus.i_wen;

`ifdef DMEM_BOUNDS_EN
  assign req_oor = (|bus.i_addr[31:DEPTH_LOG2+2]) |
                   (bus.i_wen & (bus.i_addr[1:0] != 2'b00) & (&bus.i_wstrb));
`else
  // Upper address bits alias and byte offsets are ignored in this build.
  logic addr_unused;
  assign addr_unused = ^{bus.i_addr[31:DEPTH_LOG2+2], bus.i_addr[1:0]};
  assign req_oor     = 1'b0;
`endif

  if (LATENCY == 0) begin : g_direct
    logic rst_unused;
    assign rst_unused = rst;

    // Byte-lane write commits on the edge while the write request is high.
    always_ff @(posedge clk) begin
      if (bus.i_wen && !req_oor) begin
        for (int unsigned k = 0; k < NB; k++) begin
          if (bus.i_wstrb[k]) mem[idx][8*k +: 8] <= bus.i_wdata[8*k +: 8];
        end
      end
    end

    // Combinational read path; never stalls.
    always_comb begin
      bus.o_stall  = 1'b0;
      bus.o_rvalid = bus.i_ren & ~bus.i_wen;
      bus.o_rdata  = req_oor ? '0 : mem[idx];
`ifdef DMEM_BOUNDS_EN
      bus.o_err    = req & req_oor;
`endif
    end
  end else begin : g_fsm
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state, state_n;
    logic [3:0]            cnt;
    logic [DEPTH_LOG2-1:0] cap_idx;
    logic [DATA_W-1:0]     cap_wdata;
    logic [NB-1:0]         cap_wstrb;
    logic                  cap_we;
    logic                  cap_oor;
    logic [DATA_W-1:0]     rdata_q;
    logic                  commit;

    assign commit = (state == BUSY) && (cnt == 4'd0);

    // State, latency counter, captured request and read data register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state     <= IDLE;
        cnt       <= '0;
        cap_idx   <= '0;
        cap_wdata <= '0;
        cap_wstrb <= '0;
        cap_we    <= 1'b0;
        cap_oor   <= 1'b0;
        rdata_q   <= '0;
      end else begin
        state <= state_n;
        if (state == IDLE && req) begin
          cnt       <= 4'(LATENCY - 1);
          cap_idx   <= idx;
          cap_wdata <= bus.i_wdata;
          cap_wstrb <= bus.i_wstrb;
          cap_we    <= bus.i_wen;
          cap_oor   <= req_oor;
        end else if (state == BUSY && cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end
        if (commit && !cap_we) rdata_q <= cap_oor ? '0 : mem[cap_idx];
      end
    end

    // Captured write commits at the end of the last BUSY cycle; a reset
    // before then returns the FSM to IDLE and the write never happens.
    always_ff @(posedge clk) begin
      if (commit && cap_we && !cap_oor) begin
        for (int unsigned k = 0; k < NB; k++) begin
          if (cap_wstrb[k]) mem[cap_idx][8*k +: 8] <= cap_wdata[8*k +: 8];
        end
      end
    end

    // Next state and handshake outputs; DONE always returns to IDLE so a
    // request still held there is not accepted a second time.
    always_comb begin
      state_n      = state;
      bus.o_stall  = 1'b0;
      bus.o_rvalid = 1'b0;
      bus.o_rdata  = rdata_q;
`ifdef DMEM_BOUNDS_EN
      bus.o_err    = (state == DONE) & cap_oor;
`endif
      case (state)
        IDLE: begin
          if (req) begin
            bus.o_stall = 1'b1;
            state_n     = BUSY;
          end
        end
        BUSY: begin
          bus.o_stall = 1'b1;
          if (cnt == 4'd0) state_n = DONE;
        end
        DONE: begin
          bus.o_rvalid = ~cap_we;
          state_n      = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_stall.sv
// tb_dmem_stall: four dmem_stall instances (LATENCY 2, 0, 4, 3) on one clock.
// Expected read data goes into a scoreboard queue when a read is issued and
// is popped when the DUT signals o_rvalid. Stall cycles are counted after the
// request cycle until DONE (o_stall low).
module tb_dmem_stall;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt++;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DMEM_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        rst    [4];
  logic        ren    [4];
  logic        wen    [4];
  logic [3:0]  strb   [4];
  logic [31:0] addr   [4];
  logic [31:0] wdata  [4];
  logic [31:0] rdata  [4];
  logic        rvalid [4];
  logic        stall  [4];
`ifdef DMEM_BOUNDS_EN
  logic        err    [4];
`endif

  logic [31:0] exp_q[$];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : (g == 1) ? 0 : (g == 2) ? 4 : 3;
    dmem_stall_if #(.DATA_W(32)) bus ();
    assign bus.i_ren   = ren[g];
    assign bus.i_wen   = wen[g];
    assign bus.i_wstrb = strb[g];
    assign bus.i_addr  = addr[g];
    assign bus.i_wdata = wdata[g];
    assign rdata[g]    = bus.o_rdata;
    assign rvalid[g]   = bus.o_rvalid;
    assign stall[g]    = bus.o_stall;
`ifdef DMEM_BOUNDS_EN
    assign err[g]      = bus.o_err;
`endif
    dmem_stall #(.DATA_W(32), .DEPTH_LOG2(10), .LATENCY(LAT)) dut (
      .clk (clk),
      .rst (rst[g]),
      .bus (bus)
    );
  end

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 0;
      2:       return 4;
      default: return 3;
    endcase
  endfunction

  // One complete access on DUT k; starts and ends 1 time unit after a rising edge.
  task automatic access(input int k, input logic re, input logic we,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic [31:0] exp_rd,
                        input logic exp_err, input bit scramble, input string tag);
    int lat;
    int n;
    logic [31:0] want;
    lat = lat_of(k);
    if (re && !we) exp_q.push_back(exp_rd);
    ren[k] = re; wen[k] = we; addr[k] = a; wdata[k] = wd; strb[k] = st;
    #4;
    if (lat == 0) begin
      n_checks++;
      if (stall[k] !== 1'b0) begin
        n_fail++; $display("FAIL %s stall0: got %b want 0", tag, stall[k]);
      end
    end else begin
      n_checks++;
      if (stall[k] !== 1'b1) begin
        n_fail++; $display("FAIL %s req_stall: got %b want 1", tag, stall[k]);
      end
`ifdef DMEM_BOUNDS_EN
      n_checks++;
      if (err[k] !== 1'b0) begin
        n_fail++; $display("FAIL %s err_early: got %b want 0", tag, err[k]);
      end
`endif
      n = 0;
      @(posedge clk); #5;
      while (stall[k] === 1'b1 && n < 64) begin
        n++;
        if (scramble) begin addr[k] = a ^ 32'h100; wdata[k] = ~wd; end
        @(posedge clk); #5;
      end
      addr[k] = a; wdata[k] = wd;
      n_checks++;
      if (n != lat) begin
        n_fail++; $display("FAIL %s stall_cycles: got %0d want %0d", tag, n, lat);
      end
    end
    n_checks++;
    if (rvalid[k] !== (re & ~we)) begin
      n_fail++; $display("FAIL %s rvalid: got %b want %b", tag, rvalid[k], re & ~we);
    end
    if (rvalid[k] === 1'b1 && re && !we) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL %s scoreboard: got empty queue want entry", tag);
      end else begin
        want = exp_q.pop_front();
        if (rdata[k] !== want) begin
          n_fail++; $display("FAIL %s rdata: got %h want %h", tag, rdata[k], want);
        end
      end
    end
`ifdef DMEM_BOUNDS_EN
    n_checks++;
    if (err[k] !== exp_err) begin
      n_fail++; $display("FAIL %s err: got %b want %b", tag, err[k], exp_err);
    end
`else
    if (exp_err) $display("note: %s expects o_err only in bounds build", tag);
`endif
    @(posedge clk); #1;
    ren[k] = 1'b0; wen[k] = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b1; ren[k] = 1'b0; wen[k] = 1'b0;
      strb[k] = 4'h0; addr[k] = '0; wdata[k] = '0;
    end
    repeat (5) @(posedge clk);
    #5;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (stall[k] !== 1'b0 || rvalid[k] !== 1'b0) begin
        n_fail++; $display("FAIL reset_hs[%0d]: got stall=%b rvalid=%b want 0/0", k, stall[k], rvalid[k]);
      end
      if (lat_of(k) != 0) begin
        n_checks++;
        if (rdata[k] !== 32'h0) begin
          n_fail++; $display("FAIL reset_rdata[%0d]: got %h want 0", k, rdata[k]);
        end
      end
`ifdef DMEM_BOUNDS_EN
      n_checks++;
      if (err[k] !== 1'b0) begin
        n_fail++; $display("FAIL reset_err[%0d]: got %b want 0", k, err[k]);
      end
`endif
    end
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) rst[k] = 1'b0;
  endtask

  task automatic test_write_read();
    access(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, '0, 1'b0, 1'b0, "wr40");
    access(0, 1'b1, 1'b0, 32'h40, '0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b0, "rd40");
  endtask

  task automatic test_byte_lanes();
    access(0, 1'b0, 1'b1, 32'h80, 32'h11223344, 4'hF, '0, 1'b0, 1'b0, "wr80_full");
    access(0, 1'b0, 1'b1, 32'h80, 32'h000000AA, 4'h1, '0, 1'b0, 1'b0, "wr80_lane0");
    access(0, 1'b1, 1'b0, 32'h80, '0, 4'h0, 32'h112233AA, 1'b0, 1'b0, "rd80");
    access(0, 1'b0, 1'b1, 32'h80, 32'hBBCC0000, 4'hC, '0, 1'b0, 1'b0, "wr80_hi");
    access(0, 1'b1, 1'b0, 32'h80, '0, 4'h0, 32'hBBCC33AA, 1'b0, 1'b0, "rd80_hi");
  endtask

  task automatic test_capture();
    access(0, 1'b0, 1'b1, 32'hC0, 32'hA5A5A5A5, 4'hF, '0, 1'b0, 1'b1, "wrC0_scr");
    access(0, 1'b1, 1'b0, 32'hC0, '0, 4'h0, 32'hA5A5A5A5, 1'b0, 1'b1, "rdC0_scr");
  endtask

  task automatic test_zero_latency();
    access(1, 1'b0, 1'b1, 32'h4, 32'h5, 4'hF, '0, 1'b0, 1'b0, "l0_wr4");
    access(1, 1'b1, 1'b0, 32'h4, '0, 4'h0, 32'h5, 1'b0, 1'b0, "l0_rd4");
    access(1, 1'b1, 1'b1, 32'h8, 32'h77, 4'hF, '0, 1'b0, 1'b0, "l0_both8");
    access(1, 1'b1, 1'b0, 32'h8, '0, 4'h0, 32'h77, 1'b0, 1'b0, "l0_rd8");
  endtask

  task automatic test_reset_mid_access();
    access(2, 1'b0, 1'b1, 32'h10, 32'hCAFE0000, 4'hF, '0, 1'b0, 1'b0, "l4_pre");
    access(2, 1'b1, 1'b0, 32'h10, '0, 4'h0, 32'hCAFE0000, 1'b0, 1'b0, "l4_rdpre");
    ren[2] = 1'b0; wen[2] = 1'b1; addr[2] = 32'h10; wdata[2] = 32'h1234; strb[2] = 4'hF;
    @(posedge clk);
    @(posedge clk); #3;
    n_checks++;
    if (stall[2] !== 1'b1) begin
      n_fail++; $display("FAIL mid_busy_stall: got %b want 1", stall[2]);
    end
    rst[2] = 1'b1; ren[2] = 1'b0; wen[2] = 1'b0;
    #1;
    n_checks++;
    if (stall[2] !== 1'b0 || rvalid[2] !== 1'b0 || rdata[2] !== 32'h0) begin
      n_fail++; $display("FAIL mid_rst: got stall=%b rvalid=%b rdata=%h want 0/0/0", stall[2], rvalid[2], rdata[2]);
    end
    @(posedge clk);
    @(posedge clk); #1;
    rst[2] = 1'b0;
    access(2, 1'b1, 1'b0, 32'h10, '0, 4'h0, 32'hCAFE0000, 1'b0, 1'b0, "l4_dropped");
    access(2, 1'b1, 1'b1, 32'h20, 32'h77, 4'hF, '0, 1'b0, 1'b0, "l4_both20");
    access(2, 1'b1, 1'b0, 32'h20, '0, 4'h0, 32'h77, 1'b0, 1'b0, "l4_rd20");
  endtask

  task automatic test_alias();
    access(0, 1'b0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, '0, 1'b0, 1'b0, "wr0");
    access(0, 1'b0, 1'b1, 32'h1000, 32'h99, 4'hF, '0, BOUNDS, 1'b0, "wr1000");
    access(0, 1'b1, 1'b0, 32'h0, '0, 4'h0, BOUNDS ? 32'h0BADF00D : 32'h99, 1'b0, 1'b0, "rd0");
    if (BOUNDS)
      access(0, 1'b1, 1'b0, 32'h1000, '0, 4'h0, 32'h0, 1'b1, 1'b0, "rd1000");
  endtask

  task automatic test_back_to_back();
    int t0;
    for (int i = 0; i < 4; i++)
      access(3, 1'b0, 1'b1, 32'h200 + 32'(4*i), 32'h10000000 + 32'(i), 4'hF, '0, 1'b0, 1'b0, "b2b_pre");
    t0 = cyc_cnt;
    for (int i = 0; i < 4; i++)
      access(3, 1'b1, 1'b0, 32'h200 + 32'(4*i), '0, 4'h0, 32'h10000000 + 32'(i), 1'b0, 1'b0, "b2b_rd");
    n_checks++;
    if (cyc_cnt - t0 != 20) begin
      n_fail++; $display("FAIL b2b_cycles: got %0d want 20", cyc_cnt - t0);
    end
    #4;
    n_checks++;
    if (stall[3] !== 1'b0 || rvalid[3] !== 1'b0) begin
      n_fail++; $display("FAIL b2b_no_reaccept: got stall=%b rvalid=%b want 0/0", stall[3], rvalid[3]);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_capture();
    test_zero_latency();
    test_reset_mid_access();
    test_alias();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
